e_muldiv_unit: RTL and testbench
================================

// Module: e_muldiv_unit
// PURPOSE
//  E-stage multiply/divide unit. Produces the HI/LO operand that the E->M pipeline
//  register carries forward as HiloIn. Runs MULT/MULTU/DIVU/DIV over a fixed multi-cycle
//  latency, with a Start/Busy handshake toward the stall logic.
//  The decode-stage stall unit stalls any MD-class instruction while (Start | Busy).
// PARAMETERS
//  MUL_DELAY  5   cycles Busy stays high after a MULT/MULTU start
//  DIV_DELAY  10  cycles Busy stays high after a DIV/DIVU start
// PORTS
//  Clk      in   1   clock, single domain, rising edge
//  Reset    in   1   synchronous, active-high reset
//  Start    in   1   one-cycle pulse: launch MDOp (MULT/MULTU/DIV/DIVU) on A,B
//  MDOp     in   4   operation code (header.v `MD_*); qualifies Start and the MT/MF ops
//  A        in   32  rs operand (forwarded value)
//  B        in   32  rt operand (forwarded value)
//  Flush    in   1   cancel in-flight op (active only with MDU_CANCEL_EN)
//  Busy     out  1   operation in flight
//  HiloOut  out  32  MFHI ? HI : LO, combinational; feeds the M register's HiloIn
//  HiOut    out  32  architectural HI (debug/trace)
//  LoOut    out  32  architectural LO (debug/trace)
// BEHAVIOUR
//  Reset: HI=LO=0, cnt=0, Busy=0, pending=0; HiloOut=0. Reset mid-op discards the op.
//  Start in cycle T with Busy=0:
//   - operands are latched, the result is computed into pend_hi/pend_lo, and
//     cnt <= MUL_DELAY or DIV_DELAY.
//   - Busy = (cnt != 0), so it is high in cycles T+1 .. T+N.
//   - HI/LO <= pending at the edge that ends cycle T+N (cnt 1->0).
//   - Busy is low in T+N+1, and MFHI/MFLO then read the new values.
//  MULT: {HI,LO} = $signed(A)*$signed(B). MULTU: the unsigned 64-bit product.
//  DIV:  LO = signed quotient (truncated toward zero); HI = remainder with the sign of A.
//  DIVU: unsigned quotient and remainder.
//  Divide by zero (B==0): the op still occupies DIV_DELAY cycles; HI/LO stay unchanged.
//  MTHI/MTLO: HI/LO <= A at the end of the issuing cycle if Busy=0; ignored if Busy=1.
//  MFHI/MFLO: pure reads; HiloOut = 0 for any other MDOp.
//  Start while Busy=1 is a protocol violation: it is ignored and flagged by a sim $display.
//  Start with a non-mult/div MDOp does nothing.
//  FSM: IDLE (cnt==0) -> RUN on Start; RUN -> IDLE at commit. Back-to-back ops are
//   allowed: Start in T+N+1 is legal.
// CONFIGURATION
//  `MDU_CANCEL_EN defined:
//   - Flush=1 zeroes cnt and pending at the next edge, with no HI/LO commit.
//   - Flush has priority over Start in the same cycle.
//   - Used when the issuing instruction is squashed.
//  `MDU_CANCEL_EN undefined: the Flush port is ignored and ops always run to commit.
// STRUCTURE
//  header.v holds:
//   - `MD_NONE/MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO encodings
//   - `MD_OP_LEN
//   - MUL_DELAY/DIV_DELAY defaults
//  Sub-module md_compute: combinational A,B,op -> {hi,lo} result. This unit owns the
//  counter and the HI/LO state.
// TESTING
//  Reset, then MFHI -> HiloOut=0, Busy=0.
//  MULT A=-3 B=7 at T -> Busy 1 for T+1..T+5; at T+6 HI=FFFFFFFF, LO=FFFFFFEB.
//  DIV A=-7 B=2 -> after 10 Busy cycles LO=FFFFFFFD, HI=FFFFFFFF.
//  DIVU A=7 B=2 -> LO=3, HI=1.
//  MTLO 0x1234 then DIVU B=0 -> LO stays 0x1234 after Busy falls.
//  Reset asserted at T+3 of a MULT -> HI=LO=0 and Busy=0 next cycle.
//  Start during Busy -> no effect.
//  MDU_CANCEL_EN on: Flush at T+2 of DIV 9/4 -> Busy=0 at T+3; HI/LO hold their old values.

Source files
------------

// File: rtl/e_muldiv_unit_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide unit.
package e_muldiv_unit_pkg;

  localparam int unsigned MdOpLen = 4;

  typedef enum logic [MdOpLen-1:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMfhi  = 4'd5,
    MdMflo  = 4'd6,
    MdMthi  = 4'd7,
    MdMtlo  = 4'd8
  } md_op_e;

  localparam int unsigned MulDelayDefault = 5;
  localparam int unsigned DivDelayDefault = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

  function automatic logic is_div_op(md_op_e op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_start_op(md_op_e op);
    return (op == MdMult) || (op == MdMultu) || is_div_op(op);
  endfunction

endpackage

// File: rtl/e_muldiv_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface e_muldiv_unit_if;
  import e_muldiv_unit_pkg::*;

  logic        Start;
  md_op_e      MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic [31:0] HiloOut;
  logic [31:0] HiOut;
  logic [31:0] LoOut;

  modport master (
    output Start, MDOp, A, B, Flush,
    input  Busy, HiloOut, HiOut, LoOut
  );

  modport slave (
    input  Start, MDOp, A, B, Flush,
    output Busy, HiloOut, HiOut, LoOut
  );

endinterface

// File: rtl/e_muldiv_unit_md_compute.sv
// Combinational MULT/MULTU/DIV/DIVU datapath; wr_o is low for divide by zero
// and for any op that does not produce a HI/LO result.
module e_muldiv_unit_md_compute
  import e_muldiv_unit_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  md_op_e      op_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [63:0] prod_s, prod_u;

  always_comb begin
    hi_o   = '0;
    lo_o   = '0;
    wr_o   = 1'b0;
    a_neg  = (op_i == MdDiv) && a_i[31];
    b_neg  = (op_i == MdDiv) && b_i[31];
    // Divide on magnitudes so -2^31 / -1 wraps to 0x80000000 instead of trapping.
    a_mag  = a_neg ? -a_i : a_i;
    b_mag  = b_neg ? -b_i : b_i;
    q_mag  = (b_mag != '0) ? (a_mag / b_mag) : '0;
    r_mag  = (b_mag != '0) ? (a_mag % b_mag) : '0;
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u = {32'd0, a_i} * {32'd0, b_i};

    case (op_i)
      MdMult: begin
        {hi_o, lo_o} = prod_s;
        wr_o         = 1'b1;
      end
      MdMultu: begin
        {hi_o, lo_o} = prod_u;
        wr_o         = 1'b1;
      end
      MdDiv, MdDivu: begin
        lo_o = (a_neg ^ b_neg) ? -q_mag : q_mag;
        hi_o = a_neg ? -r_mag : r_mag;
        wr_o = (b_i != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU plus HI/LO state.
// Define MDU_CANCEL_EN to let Flush cancel an in-flight op.
module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_DELAY = MulDelayDefault,
  parameter int unsigned DIV_DELAY = DivDelayDefault
) (
  input  logic            Clk,
  input  logic            Reset,
  e_muldiv_unit_if.slave  bus
);

  localparam int unsigned MaxDelay = (MUL_DELAY > DIV_DELAY) ? MUL_DELAY : DIV_DELAY;
  localparam int unsigned CntW     = $clog2(MaxDelay + 1);

  md_state_e   st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  logic        busy, start_ok, flush;

`ifdef MDU_CANCEL_EN
  assign flush = bus.Flush;
`else
  logic unused_flush;
  assign unused_flush = bus.Flush;
  assign flush        = 1'b0;
`endif

  e_muldiv_unit_md_compute u_md_compute (
    .a_i  (bus.A),
    .b_i  (bus.B),
    .op_i (bus.MDOp),
    .hi_o (res_hi),
    .lo_o (res_lo),
    .wr_o (res_wr)
  );

  assign busy     = (cnt_q != '0);
  assign start_ok = bus.Start && !busy && is_start_op(bus.MDOp);

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (flush) begin
      st_d      = StIdle;
      cnt_d     = '0;
      pend_hi_d = '0;
      pend_lo_d = '0;
      pend_wr_d = 1'b0;
    end else begin
      case (st_q)
        StIdle: begin
          if (start_ok) begin
            st_d      = StRun;
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = res_wr;
            cnt_d     = is_div_op(bus.MDOp) ? CntW'(DIV_DELAY) : CntW'(MUL_DELAY);
          end
        end
        StRun: begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
          if (cnt_q <= CntW'(1)) begin
            st_d      = StIdle;
            pend_hi_d = '0;
            pend_lo_d = '0;
            pend_wr_d = 1'b0;
            if (pend_wr_q) begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
          end
        end
        default: st_d = StIdle;
      endcase
    end

    // Moves are only honoured while no op is in flight.
    if (!busy && (bus.MDOp == MdMthi)) hi_d = bus.A;
    if (!busy && (bus.MDOp == MdMtlo)) lo_d = bus.A;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q      <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    bus.HiloOut = '0;
    case (bus.MDOp)
      MdMfhi:  bus.HiloOut = hi_q;
      MdMflo:  bus.HiloOut = lo_q;
      default: bus.HiloOut = '0;
    endcase
  end

  assign bus.Busy  = busy;
  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed self-checking bench for e_muldiv_unit; Flush scenarios follow MDU_CANCEL_EN.
module tb_e_muldiv_unit;
  import e_muldiv_unit_pkg::*;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  e_muldiv_unit_if bus ();

  e_muldiv_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (!Reset && bus.Start && bus.Busy) $display("note: Start while Busy ignored");
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Issue one op and count the Busy cycles that follow it (bounded).
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic mt(input md_op_e op, input logic [31:0] v);
    bus.MDOp = op;
    bus.A    = v;
    tick();
    bus.MDOp = MdNone;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    tick();
    Reset    = 1'b0;
    bus.MDOp = MdMfhi;
    #1;
    checks++;
    if (bus.HiloOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h want %h", bus.HiloOut, 32'd0);
    end
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.Busy);
    end
    checks++;
    if ({bus.HiOut, bus.LoOut} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo_regs got %h want 0", {bus.HiOut, bus.LoOut});
    end
    bus.MDOp = MdNone;
  endtask

  task automatic test_mult;
    int n;
    run_op(MdMult, 32'hFFFF_FFFD, 32'd7, n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL mult_busy_cycles got %0d want 5", n);
    end
    checks++;
    if ({bus.HiOut, bus.LoOut} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL mult_result got %h want ffffffffffffffeb", {bus.HiOut, bus.LoOut});
    end
    bus.MDOp = MdMfhi;
    #1;
    checks++;
    if (bus.HiloOut !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mfhi got %h want ffffffff", bus.HiloOut);
    end
    bus.MDOp = MdMflo;
    #1;
    checks++;
    if (bus.HiloOut !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mflo got %h want ffffffeb", bus.HiloOut);
    end
    bus.MDOp = MdNone;
    #1;
    checks++;
    if (bus.HiloOut !== 32'd0) begin
      errors++;
      $display("FAIL hilo_none got %h want 0", bus.HiloOut);
    end
    run_op(MdMultu, 32'hFFFF_FFFF, 32'd2, n);
    checks++;
    if ({bus.HiOut, bus.LoOut} !== 64'h0000_0001_FFFF_FFFE || n !== 5) begin
      errors++;
      $display("FAIL multu got %h/%0d want 00000001fffffffe/5", {bus.HiOut, bus.LoOut}, n);
    end
  endtask

  task automatic test_div;
    int n;
    run_op(MdDiv, 32'hFFFF_FFF9, 32'd2, n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL div_busy_cycles got %0d want 10", n);
    end
    checks++;
    if (bus.LoOut !== 32'hFFFF_FFFD || bus.HiOut !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg_a got lo %h hi %h want fffffffd ffffffff", bus.LoOut, bus.HiOut);
    end
    run_op(MdDiv, 32'd7, 32'hFFFF_FFFE, n);
    checks++;
    if (bus.LoOut !== 32'hFFFF_FFFD || bus.HiOut !== 32'd1) begin
      errors++;
      $display("FAIL div_neg_b got lo %h hi %h want fffffffd 00000001", bus.LoOut, bus.HiOut);
    end
    run_op(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++;
    if (bus.LoOut !== 32'h8000_0000 || bus.HiOut !== 32'd0) begin
      errors++;
      $display("FAIL div_ovf got lo %h hi %h want 80000000 00000000", bus.LoOut, bus.HiOut);
    end
    run_op(MdDivu, 32'd7, 32'd2, n);
    checks++;
    if (bus.LoOut !== 32'd3 || bus.HiOut !== 32'd1 || n !== 10) begin
      errors++;
      $display("FAIL divu got lo %h hi %h n %0d want 3 1 10", bus.LoOut, bus.HiOut, n);
    end
  endtask

  task automatic test_div_by_zero;
    int n;
    mt(MdMthi, 32'h0000_ABCD);
    mt(MdMtlo, 32'h0000_1234);
    checks++;
    if (bus.LoOut !== 32'h1234 || bus.HiOut !== 32'hABCD) begin
      errors++;
      $display("FAIL mt_regs got lo %h hi %h want 1234 abcd", bus.LoOut, bus.HiOut);
    end
    run_op(MdDivu, 32'd5, 32'd0, n);
    checks++;
    if (n !== 10 || bus.LoOut !== 32'h1234 || bus.HiOut !== 32'hABCD) begin
      errors++;
      $display("FAIL div0 got n %0d lo %h hi %h want 10 1234 abcd", n, bus.LoOut, bus.HiOut);
    end
  endtask

  task automatic test_busy_ignores;
    int n;
    bus.Start = 1'b1;
    bus.MDOp  = MdMult;
    bus.A     = 32'd2;
    bus.B     = 32'd3;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MdMthi;
    bus.A     = 32'hDEAD;
    tick();
    bus.Start = 1'b1;
    bus.MDOp  = MdDivu;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL start_busy_cycles got %0d want 3", n);
    end
    checks++;
    if (bus.HiOut !== 32'd0 || bus.LoOut !== 32'd6) begin
      errors++;
      $display("FAIL start_busy_result got hi %h lo %h want 0 6", bus.HiOut, bus.LoOut);
    end
    // A start with a move op must not launch anything.
    bus.Start = 1'b1;
    bus.MDOp  = MdMtlo;
    bus.A     = 32'd9;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL start_non_md_busy got %b want 0", bus.Busy);
    end
  endtask

  task automatic test_reset_mid_op;
    bus.Start = 1'b1;
    bus.MDOp  = MdMult;
    bus.A     = 32'd3;
    bus.B     = 32'd4;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HiOut !== 32'd0 || bus.LoOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got busy %b hi %h lo %h want 0 0 0", bus.Busy, bus.HiOut,
               bus.LoOut);
    end
    repeat (6) tick();
    checks++;
    if (bus.LoOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_late got lo %h want 0", bus.LoOut);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    run_op(MdMult, 32'd5, 32'd6, n);
    checks++;
    if (bus.LoOut !== 32'd30 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got lo %h busy %b want 1e 0", bus.LoOut, bus.Busy);
    end
    run_op(MdDivu, 32'd9, 32'd4, n);
    checks++;
    if (n !== 10 || bus.LoOut !== 32'd2 || bus.HiOut !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second got n %0d lo %h hi %h want 10 2 1", n, bus.LoOut, bus.HiOut);
    end
  endtask

  task automatic test_flush;
    int n;
    mt(MdMthi, 32'h55);
    mt(MdMtlo, 32'h66);
`ifdef MDU_CANCEL_EN
    bus.Start = 1'b1;
    bus.MDOp  = MdDiv;
    bus.A     = 32'd9;
    bus.B     = 32'd4;
    tick();
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    tick();
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got %b want 0", bus.Busy);
    end
    repeat (10) tick();
    checks++;
    if (bus.HiOut !== 32'h55 || bus.LoOut !== 32'h66) begin
      errors++;
      $display("FAIL flush_hold got hi %h lo %h want 55 66", bus.HiOut, bus.LoOut);
    end
    bus.Flush = 1'b1;
    bus.Start = 1'b1;
    bus.MDOp  = MdMult;
    bus.A     = 32'd3;
    bus.B     = 32'd3;
    tick();
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_prio_busy got %b want 0", bus.Busy);
    end
    repeat (6) tick();
    checks++;
    if (bus.LoOut !== 32'h66) begin
      errors++;
      $display("FAIL flush_prio_lo got %h want 66", bus.LoOut);
    end
`else
    bus.Flush = 1'b1;
    run_op(MdDivu, 32'd9, 32'd4, n);
    bus.Flush = 1'b0;
    checks++;
    if (n !== 10 || bus.LoOut !== 32'd2 || bus.HiOut !== 32'd1) begin
      errors++;
      $display("FAIL flush_ignored got n %0d lo %h hi %h want 10 2 1", n, bus.LoOut,
               bus.HiOut);
    end
`endif
  endtask

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = MdNone;
    bus.A     = '0;
    bus.B     = '0;
    bus.Flush = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_ignores();
    test_reset_mid_op();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
